// File: rtl/cpu_pkg.sv
// Shared CPU definitions: writeback widths, functional unit codes and the
// writeback entry record carried from execution units to the writeback mux.
package cpu_pkg;

    localparam int WB_ADDR_W = 6;
    localparam int WB_DATA_W = 64;

    localparam int FU_FX     = 0;
    localparam int FU_FP     = 1;
    localparam int FU_LDST   = 2;
    localparam int FU_BRANCH = 3;
    localparam int FU_TRAP   = 4;

    typedef struct packed {
        logic                 reg1_en;
        logic [WB_ADDR_W-1:0] reg1_addr;
        logic [WB_DATA_W-1:0] reg1_value;
        logic                 reg2_en;
        logic [WB_ADDR_W-1:0] reg2_addr;
        logic [WB_DATA_W-1:0] reg2_value;
    } wb_entry_t;

endpackage

// File: rtl/ls_writeback_queue_if.sv
// Load/store result input handshake and head-of-queue writeback output bundle.
// Handshake: a result transfers on a rising edge where LSValid_i && LSReady_o;
// the head transfers where LSOutputEnable_o && LSGrant_i. LSReady_o ignores LSGrant_i.
interface ls_writeback_queue_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W
) ();

    logic              LSValid_i;
    logic              LSReady_o;
    logic              LSReg1WritebackEnable_i;
    logic              LSReg2WritebackEnable_i;
    logic [ADDR_W-1:0] LSReg1WritebackAddress_i;
    logic [ADDR_W-1:0] LSReg2WritebackAddress_i;
    logic [DATA_W-1:0] LSReg1WritebackValue_i;
    logic [DATA_W-1:0] LSReg2WritebackValue_i;

    logic              LSOutputEnable_o;
    logic              LSGrant_i;
    logic [1:0]        LSFunctionalUnitCode_o;
    logic              LSReg1WritebackEnable_o;
    logic              LSReg2WritebackEnable_o;
    logic [ADDR_W-1:0] LSReg1WritebackAddress_o;
    logic [ADDR_W-1:0] LSReg2WritebackAddress_o;
    logic [DATA_W-1:0] LSReg1WritebackValue_o;
    logic [DATA_W-1:0] LSReg2WritebackValue_o;

    modport master (
        output LSValid_i, LSReg1WritebackEnable_i, LSReg2WritebackEnable_i,
               LSReg1WritebackAddress_i, LSReg2WritebackAddress_i,
               LSReg1WritebackValue_i, LSReg2WritebackValue_i, LSGrant_i,
        input  LSReady_o, LSOutputEnable_o, LSFunctionalUnitCode_o,
               LSReg1WritebackEnable_o, LSReg2WritebackEnable_o,
               LSReg1WritebackAddress_o, LSReg2WritebackAddress_o,
               LSReg1WritebackValue_o, LSReg2WritebackValue_o
    );

    modport slave (
        input  LSValid_i, LSReg1WritebackEnable_i, LSReg2WritebackEnable_i,
               LSReg1WritebackAddress_i, LSReg2WritebackAddress_i,
               LSReg1WritebackValue_i, LSReg2WritebackValue_i, LSGrant_i,
        output LSReady_o, LSOutputEnable_o, LSFunctionalUnitCode_o,
               LSReg1WritebackEnable_o, LSReg2WritebackEnable_o,
               LSReg1WritebackAddress_o, LSReg2WritebackAddress_o,
               LSReg1WritebackValue_o, LSReg2WritebackValue_o
    );

endinterface

// File: rtl/ls_writeback_queue.sv
// FIFO buffering load/store unit writeback results until the writeback mux
// grants them. Results with no write enable set are accepted but never stored.
module ls_writeback_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int ADDR_W       = WB_ADDR_W,
    parameter int DATA_W       = WB_DATA_W,
    parameter int LdStUnitCode = FU_LDST
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    ls_writeback_queue_if.slave      bus,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              reg1_en;
        logic [ADDR_W-1:0] reg1_addr;
        logic [DATA_W-1:0] reg1_value;
        logic              reg2_en;
        logic [ADDR_W-1:0] reg2_addr;
        logic [DATA_W-1:0] reg2_value;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           in_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             ready;
    logic             not_empty;
    logic             accept;
    logic             store;
    logic             pop;

    assign ready     = (count_q < CNT_W'(DEPTH));
    assign not_empty = (count_q != '0);
    assign accept    = bus.LSValid_i && ready;
    // An accepted result that writes nothing is consumed here and never queued.
    assign store     = accept && (bus.LSReg1WritebackEnable_i || bus.LSReg2WritebackEnable_i);
    assign pop       = not_empty && bus.LSGrant_i;

    assign in_entry = '{
        reg1_en:    bus.LSReg1WritebackEnable_i,
        reg1_addr:  bus.LSReg1WritebackAddress_i,
        reg1_value: bus.LSReg1WritebackValue_i,
        reg2_en:    bus.LSReg2WritebackEnable_i,
        reg2_addr:  bus.LSReg2WritebackAddress_i,
        reg2_value: bus.LSReg2WritebackValue_i
    };

    always_ff @(posedge clock_i) begin
        if (store) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (bus.LSValid_i && !ready) begin
                overflow_q <= 1'b1;
            end
            if (flush_i) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (store) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({store, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Head is read straight from storage; a push only becomes visible once the count has moved.
    assign head = mem[rd_ptr];

    assign bus.LSReady_o                = ready;
    assign bus.LSOutputEnable_o         = not_empty;
    assign bus.LSFunctionalUnitCode_o   = 2'(LdStUnitCode);
    assign bus.LSReg1WritebackEnable_o  = not_empty && head.reg1_en;
    assign bus.LSReg2WritebackEnable_o  = not_empty && head.reg2_en;
    assign bus.LSReg1WritebackAddress_o = head.reg1_addr;
    assign bus.LSReg2WritebackAddress_o = head.reg2_addr;
    assign bus.LSReg1WritebackValue_o   = head.reg1_value;
    assign bus.LSReg2WritebackValue_o   = head.reg2_value;

    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_ls_writeback_queue.sv
// Directed bench for ls_writeback_queue: fill, overflow, no-bypass, streaming
// across pointer wrap, dropped results, flush and mid-run reset.
module tb_ls_writeback_queue;

    logic       clk;
    logic       reset_i;
    logic       flush_i;
    logic [2:0] count_o;
    logic       overflow_o;
    int         total;
    int         passed;
    logic [5:0] exp_q[$];

    ls_writeback_queue_if #(.ADDR_W(6), .DATA_W(64)) bus ();

    ls_writeback_queue #(.DEPTH(4), .ADDR_W(6), .DATA_W(64), .LdStUnitCode(2)) dut (
        .clock_i    (clk),
        .reset_i    (reset_i),
        .flush_i    (flush_i),
        .bus        (bus.slave),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.LSValid_i                = 1'b0;
        bus.LSGrant_i                = 1'b0;
        bus.LSReg1WritebackEnable_i  = 1'b0;
        bus.LSReg2WritebackEnable_i  = 1'b0;
        bus.LSReg1WritebackAddress_i = '0;
        bus.LSReg2WritebackAddress_i = '0;
        bus.LSReg1WritebackValue_i   = '0;
        bus.LSReg2WritebackValue_i   = '0;
        flush_i                      = 1'b0;
    endtask

    task automatic drive_push(input logic [5:0] addr, input logic [63:0] val,
                              input logic en1, input logic en2);
        bus.LSValid_i                = 1'b1;
        bus.LSReg1WritebackEnable_i  = en1;
        bus.LSReg2WritebackEnable_i  = en2;
        bus.LSReg1WritebackAddress_i = addr;
        bus.LSReg2WritebackAddress_i = addr;
        bus.LSReg1WritebackValue_i   = val;
        bus.LSReg2WritebackValue_i   = val;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        idle_inputs();
        step();
        step();
        reset_i = 1'b1;
        total++; if (count_o !== 3'd0) $display("FAIL reset_count: got %0d want 0", count_o); else passed++;
        total++; if (bus.LSOutputEnable_o !== 1'b0) $display("FAIL reset_oe: got %b want 0", bus.LSOutputEnable_o); else passed++;
        total++; if (bus.LSReady_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.LSReady_o); else passed++;
        total++; if (overflow_o !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow_o); else passed++;
        total++; if (bus.LSReg1WritebackEnable_o !== 1'b0) $display("FAIL reset_en1: got %b want 0", bus.LSReg1WritebackEnable_o); else passed++;
        total++; if (bus.LSFunctionalUnitCode_o !== 2'd2) $display("FAIL fu_code: got %0d want 2", bus.LSFunctionalUnitCode_o); else passed++;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            drive_push(6'(i), 64'(i * 16), 1'b1, 1'b0);
            step();
        end
        idle_inputs();
        total++; if (count_o !== 3'd4) $display("FAIL fill_count: got %0d want 4", count_o); else passed++;
        total++; if (bus.LSReady_o !== 1'b0) $display("FAIL fill_ready: got %b want 0", bus.LSReady_o); else passed++;
        total++; if (bus.LSReg1WritebackAddress_o !== 6'd1) $display("FAIL fill_head_addr: got %0d want 1", bus.LSReg1WritebackAddress_o); else passed++;
        total++; if (bus.LSReg1WritebackValue_o !== 64'h10) $display("FAIL fill_head_val: got %0h want 10", bus.LSReg1WritebackValue_o); else passed++;
        total++; if (bus.LSOutputEnable_o !== 1'b1) $display("FAIL fill_oe: got %b want 1", bus.LSOutputEnable_o); else passed++;
    endtask

    task automatic test_overflow();
        drive_push(6'd9, 64'h99, 1'b1, 1'b0);
        step();
        idle_inputs();
        total++; if (overflow_o !== 1'b1) $display("FAIL overflow_set: got %b want 1", overflow_o); else passed++;
        total++; if (count_o !== 3'd4) $display("FAIL overflow_count: got %0d want 4", count_o); else passed++;
        step();
        total++; if (overflow_o !== 1'b1) $display("FAIL overflow_sticky: got %b want 1", overflow_o); else passed++;
        // Drain in order; the rejected entry (addr 9) must not appear.
        for (int i = 1; i <= 4; i++) begin
            bus.LSGrant_i = 1'b1;
            total++; if (bus.LSReg1WritebackAddress_o !== 6'(i)) $display("FAIL drain_addr: got %0d want %0d", bus.LSReg1WritebackAddress_o, i); else passed++;
            step();
        end
        step();
        bus.LSGrant_i = 1'b0;
        total++; if (count_o !== 3'd0) $display("FAIL grant_empty_count: got %0d want 0", count_o); else passed++;
        total++; if (bus.LSOutputEnable_o !== 1'b0) $display("FAIL drain_oe: got %b want 0", bus.LSOutputEnable_o); else passed++;
    endtask

    task automatic test_no_bypass();
        drive_push(6'd5, 64'h55, 1'b1, 1'b0);
        bus.LSGrant_i = 1'b1;
        #1;
        total++; if (bus.LSOutputEnable_o !== 1'b0) $display("FAIL bypass_oe_same: got %b want 0", bus.LSOutputEnable_o); else passed++;
        step();
        idle_inputs();
        total++; if (bus.LSOutputEnable_o !== 1'b1) $display("FAIL bypass_oe_next: got %b want 1", bus.LSOutputEnable_o); else passed++;
        total++; if (bus.LSReg1WritebackAddress_o !== 6'd5) $display("FAIL bypass_addr: got %0d want 5", bus.LSReg1WritebackAddress_o); else passed++;
        total++; if (count_o !== 3'd1) $display("FAIL bypass_count: got %0d want 1", count_o); else passed++;
        bus.LSGrant_i = 1'b1;
        step();
        bus.LSGrant_i = 1'b0;
        total++; if (count_o !== 3'd0) $display("FAIL bypass_pop_count: got %0d want 0", count_o); else passed++;
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        for (int i = 10; i <= 11; i++) begin
            drive_push(6'(i), 64'(i), 1'b1, 1'b0);
            step();
            exp_q.push_back(6'(i));
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            drive_push(6'(12 + i), 64'(12 + i), 1'b1, 1'b0);
            bus.LSGrant_i = 1'b1;
            #1;
            total++; if (bus.LSReg1WritebackAddress_o !== exp_q[0]) $display("FAIL b2b_addr: got %0d want %0d", bus.LSReg1WritebackAddress_o, exp_q[0]); else passed++;
            step();
            void'(exp_q.pop_front());
            exp_q.push_back(6'(12 + i));
            total++; if (count_o !== 3'd2) $display("FAIL b2b_count: got %0d want 2", count_o); else passed++;
        end
        idle_inputs();
        while (exp_q.size() > 0) begin
            bus.LSGrant_i = 1'b1;
            total++; if (bus.LSReg1WritebackAddress_o !== exp_q[0]) $display("FAIL b2b_tail_addr: got %0d want %0d", bus.LSReg1WritebackAddress_o, exp_q[0]); else passed++;
            step();
            void'(exp_q.pop_front());
        end
        bus.LSGrant_i = 1'b0;
        total++; if (count_o !== 3'd0) $display("FAIL b2b_final_count: got %0d want 0", count_o); else passed++;
    endtask

    task automatic test_drop();
        drive_push(6'd30, 64'h30, 1'b0, 1'b0);
        step();
        idle_inputs();
        total++; if (count_o !== 3'd0) $display("FAIL drop_count: got %0d want 0", count_o); else passed++;
        total++; if (bus.LSOutputEnable_o !== 1'b0) $display("FAIL drop_oe: got %b want 0", bus.LSOutputEnable_o); else passed++;
        drive_push(6'd31, 64'h31, 1'b0, 1'b1);
        step();
        drive_push(6'd32, 64'h32, 1'b0, 1'b0);
        step();
        idle_inputs();
        total++; if (count_o !== 3'd1) $display("FAIL drop_count2: got %0d want 1", count_o); else passed++;
        total++; if (bus.LSReg2WritebackAddress_o !== 6'd31) $display("FAIL drop_head_addr2: got %0d want 31", bus.LSReg2WritebackAddress_o); else passed++;
        total++; if (bus.LSReg2WritebackEnable_o !== 1'b1) $display("FAIL drop_en2: got %b want 1", bus.LSReg2WritebackEnable_o); else passed++;
        total++; if (bus.LSReg1WritebackEnable_o !== 1'b0) $display("FAIL drop_en1: got %b want 0", bus.LSReg1WritebackEnable_o); else passed++;
        bus.LSGrant_i = 1'b1;
        step();
        bus.LSGrant_i = 1'b0;
        total++; if (bus.LSOutputEnable_o !== 1'b0) $display("FAIL drop_never_head: got %b want 0", bus.LSOutputEnable_o); else passed++;
    endtask

    task automatic test_flush_reset();
        for (int i = 40; i <= 42; i++) begin
            drive_push(6'(i), 64'(i), 1'b1, 1'b0);
            step();
        end
        idle_inputs();
        total++; if (count_o !== 3'd3) $display("FAIL flush_pre_count: got %0d want 3", count_o); else passed++;
        drive_push(6'd43, 64'h43, 1'b1, 1'b0);
        bus.LSGrant_i = 1'b1;
        flush_i = 1'b1;
        step();
        idle_inputs();
        total++; if (count_o !== 3'd0) $display("FAIL flush_count: got %0d want 0", count_o); else passed++;
        total++; if (bus.LSOutputEnable_o !== 1'b0) $display("FAIL flush_oe: got %b want 0", bus.LSOutputEnable_o); else passed++;
        total++; if (overflow_o !== 1'b1) $display("FAIL flush_overflow_kept: got %b want 1", overflow_o); else passed++;
        // After flush the pointers restart at 0 and a new push must come out first.
        drive_push(6'd44, 64'h44, 1'b1, 1'b0);
        step();
        drive_push(6'd45, 64'h45, 1'b1, 1'b0);
        step();
        idle_inputs();
        total++; if (bus.LSReg1WritebackAddress_o !== 6'd44) $display("FAIL flush_head_addr: got %0d want 44", bus.LSReg1WritebackAddress_o); else passed++;
        drive_push(6'd46, 64'h46, 1'b1, 1'b0);
        reset_i = 1'b0;
        step();
        reset_i = 1'b1;
        idle_inputs();
        total++; if (count_o !== 3'd0) $display("FAIL rst_count: got %0d want 0", count_o); else passed++;
        total++; if (bus.LSOutputEnable_o !== 1'b0) $display("FAIL rst_oe: got %b want 0", bus.LSOutputEnable_o); else passed++;
        total++; if (overflow_o !== 1'b0) $display("FAIL rst_overflow: got %b want 0", overflow_o); else passed++;
        total++; if (bus.LSReady_o !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.LSReady_o); else passed++;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset_i = 1'b0;
        idle_inputs();
        test_reset();
        test_fill();
        test_overflow();
        test_no_bypass();
        test_back_to_back();
        test_drop();
        test_flush_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
